// File: rtl/zone_alarm_pkg.sv
// Shared types and sizing helpers for the zone alarm controller.
// Holds the state encoding and the counter width calculation.
package zone_alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    EXIT     = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4
  } state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..maxv, never less than one bit.
  function automatic int cnt_w(input int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/alarm_down_counter.sv
// Loadable down counter that saturates at zero.
// Load takes priority over decrement; zero flags a count of 0.
module alarm_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, else step down without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/zone_alarm_ctrl.sv
// Multi-zone intrusion alarm controller with exit/entry delays,
// latched zone history and a timed siren.
module zone_alarm_ctrl
  import zone_alarm_pkg::*;
#(
  parameter int NZONES    = 4,
  parameter int EXIT_DLY  = 4,
  parameter int ENTRY_DLY = 3,
  parameter int SIREN_CYC = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm_req,
  input  logic              disarm_req,
  input  logic [NZONES-1:0] door,
  input  logic [NZONES-1:0] window,
  output logic              armed,
  output logic              exit_pend,
  output logic              entry_pend,
  output logic              siren,
  output logic              alarm_mem,
  output logic              arm_fail,
  output logic [NZONES-1:0] zone_latch
);

  localparam int CW = cnt_w(imax(EXIT_DLY, ENTRY_DLY));
  localparam int SW = cnt_w(SIREN_CYC);
  localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_DLY - 1);
  localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_DLY - 1);
  localparam logic [SW-1:0] SIREN_LD = SW'(SIREN_CYC - 1);

  state_e            state_q, state_d;
  logic [NZONES-1:0] latch_q, latch_d;
  logic              arm_fail_q, arm_fail_d;
  logic              siren_q, siren_d;

  logic              cnt_ld, cnt_en, cnt_zero;
  logic [CW-1:0]     cnt_val;
  logic              scnt_ld, scnt_en, scnt_zero;

  logic              any_win, any_door;

  assign any_win  = |window;
  assign any_door = |door;

  // Next state, zone history, siren and counter control.
  always_comb begin
    state_d    = state_q;
    latch_d    = latch_q;
    arm_fail_d = 1'b0;
    siren_d    = siren_q;
    cnt_ld     = 1'b0;
    cnt_val    = '0;
    scnt_ld    = 1'b0;
    unique case (state_q)
      DISARMED: begin
        if (arm_req && !disarm_req) begin
          if (any_win || any_door) begin
            arm_fail_d = 1'b1;
          end else begin
            state_d = EXIT;
            cnt_ld  = 1'b1;
            cnt_val = EXIT_LD;
            latch_d = '0;
          end
        end
      end
      EXIT: begin
        if (disarm_req) begin
          state_d = DISARMED;
        end else if (cnt_zero) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (disarm_req) begin
          state_d = DISARMED;
        end else if (any_win) begin
          state_d = ALARM;
          latch_d = latch_q | window;
          siren_d = 1'b1;
          scnt_ld = 1'b1;
        end else if (any_door) begin
          state_d = ENTRY;
          latch_d = latch_q | door;
          cnt_ld  = 1'b1;
          cnt_val = ENTRY_LD;
        end
      end
      ENTRY: begin
        latch_d = latch_q | door | window;
        if (disarm_req) begin
          state_d = DISARMED;
        end else if (any_win || cnt_zero) begin
          state_d = ALARM;
          siren_d = 1'b1;
          scnt_ld = 1'b1;
        end
      end
      ALARM: begin
        latch_d = latch_q | door | window;
        if (disarm_req) begin
          state_d = DISARMED;
        end else if (scnt_zero) begin
          siren_d = 1'b0;
        end
      end
      default: begin
        state_d = DISARMED;
      end
    endcase
    if (state_d != ALARM) begin
      siren_d = 1'b0;
    end
  end

  assign cnt_en  = (state_q == EXIT) || (state_q == ENTRY);
  assign scnt_en = (state_q == ALARM);

  // State and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DISARMED;
      latch_q    <= '0;
      arm_fail_q <= 1'b0;
      siren_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      latch_q    <= latch_d;
      arm_fail_q <= arm_fail_d;
      siren_q    <= siren_d;
    end
  end

  alarm_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_ld),
    .en       (cnt_en),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  alarm_down_counter #(.W(SW)) u_scnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (scnt_ld),
    .en       (scnt_en),
    .load_val (SIREN_LD),
    .zero     (scnt_zero)
  );

  assign armed      = (state_q == ARMED) || (state_q == ENTRY);
  assign exit_pend  = (state_q == EXIT);
  assign entry_pend = (state_q == ENTRY);
  assign alarm_mem  = (state_q == ALARM);
  assign siren      = siren_q;
  assign arm_fail   = arm_fail_q;
  assign zone_latch = latch_q;

endmodule

// File: doc/zone_alarm_ctrl.md
Name: zone_alarm_ctrl

Overview:
Multi-zone intrusion alarm controller. It is the sequential, parametrised successor to the single-bit door/window/arm combinational alarm.
- Each zone has an entry input (door, delayed) and an instant input (window).
- Adds exit/entry delay timers, a latched zone history and a timed siren.
- Sits between debounced sensor inputs and the siren/indicator drivers.

Parameters:
NZONES, 4, number of zones (1..16)
EXIT_DLY, 4, cycles spent in EXIT before ARMED (>=1)
ENTRY_DLY, 3, cycles allowed in ENTRY before ALARM (>=1)
SIREN_CYC, 6, cycles the siren stays high after entering ALARM (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
arm_req  input  1  one-cycle arm request
disarm_req  input  1  one-cycle disarm request (valid code already checked upstream)
door  input  NZONES  entry-delay sensors, 1 = open
window  input  NZONES  instant sensors, 1 = open
armed  output  1  high in ARMED and ENTRY
exit_pend  output  1  high in EXIT
entry_pend  output  1  high in ENTRY
siren  output  1  audible alarm
alarm_mem  output  1  high in ALARM (stays high after the siren times out)
arm_fail  output  1  one-cycle pulse when an arm request is refused
zone_latch  output  NZONES  zones that caused ENTRY/ALARM since the last arm

Behaviour:
Clocking and reset
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state = DISARMED, all outputs 0, zone_latch = 0, counters = 0.
- All outputs are registered. Every response appears on the clock edge after the stimulus (1-cycle latency).

State machine: DISARMED, EXIT, ARMED, ENTRY, ALARM
- Priority every cycle: disarm_req > window > door/timer > arm_req.
- DISARMED:
  - arm_req with door==0 and window==0: go to EXIT, load cnt = EXIT_DLY-1, clear zone_latch.
  - arm_req with any zone open: stay in DISARMED, pulse arm_fail for 1 cycle.
- EXIT: sensors ignored. disarm_req -> DISARMED. cnt==0 -> ARMED. Otherwise cnt decrements.
- ARMED:
  - disarm_req -> DISARMED.
  - Any window bit set -> ALARM, zone_latch |= window.
  - Else any door bit set -> ENTRY, load cnt = ENTRY_DLY-1, zone_latch |= door.
  - arm_req is ignored (no arm_fail).
- ENTRY:
  - disarm_req -> DISARMED.
  - Any window bit set -> ALARM.
  - cnt==0 -> ALARM.
  - Otherwise cnt decrements.
  - zone_latch |= door | window every cycle.
- ALARM:
  - On entry: siren = 1, load scnt = SIREN_CYC-1.
  - siren drops to 0 once scnt reaches 0; alarm_mem stays 1.
  - New window/door activity does NOT retrigger the siren. zone_latch keeps OR-ing in sensor bits.
  - disarm_req -> DISARMED.
- zone_latch is held in DISARMED and cleared only on a successful arm.

Counters
- cnt width = $clog2(max(EXIT_DLY, ENTRY_DLY)+1). scnt width = $clog2(SIREN_CYC+1).
- Counters never wrap: they hold at 0.

Boundary conditions
- arm_req and disarm_req in the same cycle: disarm wins. In DISARMED the cycle is a no-op with no arm_fail.
- Reset asserted mid-EXIT, mid-ENTRY or mid-ALARM: immediate return to the reset values.
- X/Z on unused zones is not tolerated; tie unused inputs to 0.

Decomposition:
- Package zone_alarm_pkg:
  - state enum (DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4, 3-bit)
  - function for the counter width.
- One sub-module: alarm_down_counter (load, en, load value, zero flag, saturating at 0). It is instantiated twice, once for cnt and once for scnt.

Test Plan (default parameters):
1. Reset, then arm_req with all sensors closed -> exit_pend=1 for 4 cycles, then armed=1, siren=0.
2. Arm with door=4'b0010 -> arm_fail pulses 1 cycle, state stays DISARMED, zone_latch=0.
3. Armed, door[0] pulses -> entry_pend=1; disarm_req on the 2nd ENTRY cycle -> all outputs 0, zone_latch=4'b0001.
4. Armed, door[2]=1, no disarm -> after 3 ENTRY cycles siren=1 for exactly 6 cycles, then siren=0 with alarm_mem=1; zone_latch=4'b0100.
5. Armed, window[3] and door[1] rise in the same cycle -> ALARM next cycle (no ENTRY), zone_latch=4'b1010. disarm_req -> DISARMED with zone_latch held. A new successful arm clears it.
6. rst_n pulled low mid-ALARM while siren=1 -> outputs 0 immediately, asynchronously. Separately, arm_req+disarm_req together in DISARMED -> no state change, no arm_fail.
